// File: rtl/mem_bridge_if.sv
// Bus-side request/response bundle between the bridge and external memory.
interface mem_bridge_if;
    logic        busValid;
    logic        busReady;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic        busWE;
    logic [31:0] busRData;

    // Bridge side: issues requests, receives ready and read data.
    modport master (
        output busValid, busAddr, busWData, busWE,
        input  busReady, busRData
    );

    // Memory side: accepts requests, returns ready and read data.
    modport slave (
        input  busValid, busAddr, busWData, busWE,
        output busReady, busRData
    );
endinterface

// File: rtl/mem_bridge.sv
// Processor-to-memory bridge with a one-entry read buffer, write-through
// update of that buffer, and a bounded wait on the memory handshake.
module mem_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpuReq,
    input  logic [31:0] cpuAddr,
    input  logic [31:0] cpuWData,
    input  logic        cpuWE,
    output logic [31:0] cpuRData,
    output logic        cpuStall,
    output logic        timeoutErr,
    mem_bridge_if.master bus
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              stateNext;

    logic                bufValid;
    logic [DATA_W-1:0]   bufAddr;
    logic [DATA_W-1:0]   bufData;
    logic [DATA_W-1:0]   capData;
    logic [DATA_W-1:0]   addrQ;
    logic [DATA_W-1:0]   wDataQ;
    logic                weQ;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cntInc;

    logic                validC;
    logic                loadReq;
    logic                timeoutHit;

    assign bus.busValid = validC;
    assign bus.busAddr  = addrQ;
    assign bus.busWData = wDataQ;
    assign bus.busWE    = weQ;

    // Saturating increment; the abandon point is the cycle whose increment
    // lands on TIMEOUT, and a same-cycle ready takes priority over it.
    always_comb begin
        cntInc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
        timeoutHit = (state == ISSUE) && !bus.busReady &&
                     (32'(cntInc) == 32'(TIMEOUT));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and processor/bus outputs; reset forces all outputs quiet.
    always_comb begin
        stateNext = state;
        cpuStall  = 1'b0;
        cpuRData  = '0;
        validC    = 1'b0;
        loadReq   = 1'b0;

        unique case (state)
            IDLE: begin
                if (cpuReq) begin
                    if (!cpuWE && bufValid && (cpuAddr == bufAddr)) begin
                        cpuRData = bufData;
                    end else begin
                        cpuStall  = 1'b1;
                        loadReq   = 1'b1;
                        stateNext = ISSUE;
                    end
                end
            end
            ISSUE: begin
                validC   = 1'b1;
                cpuStall = 1'b1;
                if (bus.busReady || timeoutHit) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                cpuRData  = weQ ? '0 : capData;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (!reset) begin
            stateNext = IDLE;
            cpuStall  = 1'b0;
            cpuRData  = '0;
            validC    = 1'b0;
            loadReq   = 1'b0;
        end
    end

    // Request latches, wait counter, captured data, read buffer and error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addrQ      <= '0;
            wDataQ     <= '0;
            weQ        <= 1'b0;
            cnt        <= '0;
            capData    <= '0;
            bufValid   <= 1'b0;
            bufAddr    <= '0;
            bufData    <= '0;
            timeoutErr <= 1'b0;
        end else begin
            if (loadReq) begin
                addrQ  <= cpuAddr;
                wDataQ <= cpuWData;
                weQ    <= cpuWE;
                cnt    <= '0;
            end
            if (state == ISSUE) begin
                if (bus.busReady) begin
                    if (!weQ) begin
                        capData  <= bus.busRData;
                        bufAddr  <= addrQ;
                        bufData  <= bus.busRData;
                        bufValid <= 1'b1;
                    end else if (addrQ == bufAddr) begin
                        bufData <= wDataQ;
                    end
                end else begin
                    cnt <= cntInc;
                    if (timeoutHit) begin
                        timeoutErr <= 1'b1;
                        capData    <= ERR_DATA;
                        bufValid   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: miss, hit, write-through, timeout boundary,
// sticky error and reset during an outstanding access.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuReq;
    logic [31:0] cpuAddr;
    logic [31:0] cpuWData;
    logic        cpuWE;
    logic [31:0] cpuRData;
    logic        cpuStall;
    logic        timeoutErr;

    int checks   = 0;
    int failures = 0;

    int          stalls;
    int          issues;
    logic [31:0] doneData;
    logic        sawValid;

    mem_bridge_if bus ();

    mem_bridge #(
        .TIMEOUT (255),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpuReq    (cpuReq),
        .cpuAddr   (cpuAddr),
        .cpuWData  (cpuWData),
        .cpuWE     (cpuWE),
        .cpuRData  (cpuRData),
        .cpuStall  (cpuStall),
        .timeoutErr(timeoutErr),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Runs one processor access; memory asserts ready on ISSUE cycle readyAt
    // (0 = never). Returns stall cycles, ISSUE cycles, data seen on the first
    // unstalled cycle and whether busValid was ever seen.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input int readyAt, input logic [31:0] rd,
                          output int nStall, output int nIssue,
                          output logic [31:0] data, output logic anyValid);
        cpuReq   = 1'b1;
        cpuAddr  = a;
        cpuWData = wd;
        cpuWE    = we;
        bus.busReady = 1'b0;
        bus.busRData = '0;
        nStall   = 0;
        nIssue   = 0;
        anyValid = 1'b0;
        #1;
        for (int n = 0; n < 600 && cpuStall; n++) begin
            nStall++;
            if (bus.busValid) begin
                anyValid = 1'b1;
                nIssue++;
                if (nIssue == readyAt) begin
                    bus.busReady = 1'b1;
                    bus.busRData = rd;
                end
            end
            @(posedge clk);
            #1;
            bus.busReady = 1'b0;
            bus.busRData = '0;
        end
        check("stall_bound", 32'(cpuStall), 32'd0);
        data = cpuRData;
        if (bus.busValid) anyValid = 1'b1;
        cpuReq = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        cpuReq       = 1'b1;
        cpuAddr      = 32'h10;
        cpuWData     = '0;
        cpuWE        = 1'b0;
        bus.busReady = 1'b0;
        bus.busRData = '0;

        // Reset state with a pending request that must stay masked.
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.busValid), 32'd0);
        check("rst_stall", 32'(cpuStall), 32'd0);
        check("rst_rdata", cpuRData, 32'd0);
        check("rst_terr", 32'(timeoutErr), 32'd0);
        check("rst_addr", bus.busAddr, 32'd0);
        cpuReq = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;

        // Read miss, ready on third ISSUE cycle.
        access(32'h10, 32'h0, 1'b0, 3, 32'hCAFE0001, stalls, issues, doneData, sawValid);
        check("miss_stall", 32'(stalls), 32'd4);
        check("miss_data", doneData, 32'hCAFE0001);
        check("miss_idle_valid", 32'(bus.busValid), 32'd0);

        // Read hit on the same address.
        access(32'h10, 32'h0, 1'b0, 1, 32'h0, stalls, issues, doneData, sawValid);
        check("hit_stall", 32'(stalls), 32'd0);
        check("hit_data", doneData, 32'hCAFE0001);
        check("hit_novalid", 32'(sawValid), 32'd0);

        // Write-through to the buffered address.
        access(32'h10, 32'h12345678, 1'b1, 1, 32'h0, stalls, issues, doneData, sawValid);
        check("wr_stall", 32'(stalls), 32'd2);
        check("wr_data", doneData, 32'd0);
        access(32'h10, 32'h0, 1'b0, 1, 32'h0, stalls, issues, doneData, sawValid);
        check("wt_stall", 32'(stalls), 32'd0);
        check("wt_data", doneData, 32'h12345678);
        check("wt_novalid", 32'(sawValid), 32'd0);

        // Write elsewhere leaves the buffer alone.
        access(32'h20, 32'h99999999, 1'b1, 1, 32'h0, stalls, issues, doneData, sawValid);
        access(32'h10, 32'h0, 1'b0, 1, 32'h0, stalls, issues, doneData, sawValid);
        check("wo_stall", 32'(stalls), 32'd0);
        check("wo_data", doneData, 32'h12345678);

        // Miss to another address replaces the buffer; old address now misses.
        access(32'h40, 32'h0, 1'b0, 1, 32'h0BADF00D, stalls, issues, doneData, sawValid);
        check("rep_stall", 32'(stalls), 32'd2);
        check("rep_data", doneData, 32'h0BADF00D);
        access(32'h10, 32'h0, 1'b0, 2, 32'h11112222, stalls, issues, doneData, sawValid);
        check("old_stall", 32'(stalls), 32'd3);
        check("old_data", doneData, 32'h11112222);

        // Ready on the last permitted ISSUE cycle is a success.
        access(32'h80, 32'h0, 1'b0, 255, 32'h55AA55AA, stalls, issues, doneData, sawValid);
        check("edge_issue", 32'(issues), 32'd255);
        check("edge_data", doneData, 32'h55AA55AA);
        check("edge_terr", 32'(timeoutErr), 32'd0);

        // Timeout: no ready at all.
        access(32'h90, 32'h0, 1'b0, 0, 32'h0, stalls, issues, doneData, sawValid);
        check("to_issue", 32'(issues), 32'd255);
        check("to_stall", 32'(stalls), 32'd256);
        check("to_data", doneData, 32'hDEADBEEF);
        check("to_terr", 32'(timeoutErr), 32'd1);

        // Buffer was invalidated: the previously buffered address misses.
        access(32'h80, 32'h0, 1'b0, 1, 32'h80808080, stalls, issues, doneData, sawValid);
        check("inv_stall", 32'(stalls), 32'd2);
        check("inv_data", doneData, 32'h80808080);
        access(32'h90, 32'h0, 1'b0, 1, 32'h90909090, stalls, issues, doneData, sawValid);
        check("to_retry_stall", 32'(stalls), 32'd2);
        check("to_retry_data", doneData, 32'h90909090);
        check("terr_sticky", 32'(timeoutErr), 32'd1);

        // Full reset clears the sticky flag.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_terr", 32'(timeoutErr), 32'd0);

        // Reset during ISSUE abandons the access, even with ready present.
        cpuReq  = 1'b1;
        cpuAddr = 32'hA0;
        cpuWE   = 1'b0;
        @(posedge clk);
        #1;
        check("mid_valid", 32'(bus.busValid), 32'd1);
        reset        = 1'b0;
        bus.busReady = 1'b1;
        bus.busRData = 32'hA0A0A0A0;
        #1;
        check("mid_rst_valid", 32'(bus.busValid), 32'd0);
        check("mid_rst_stall", 32'(cpuStall), 32'd0);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        cpuReq       = 1'b0;
        bus.busReady = 1'b0;
        bus.busRData = '0;
        #1;
        check("post_valid", 32'(bus.busValid), 32'd0);
        check("post_stall", 32'(cpuStall), 32'd0);
        check("post_addr", bus.busAddr, 32'd0);
        check("post_terr", 32'(timeoutErr), 32'd0);
        @(posedge clk);
        #1;
        access(32'hA0, 32'h0, 1'b0, 1, 32'h0A0A0A0A, stalls, issues, doneData, sawValid);
        check("post_miss_stall", 32'(stalls), 32'd2);
        check("post_miss_data", doneData, 32'h0A0A0A0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the number of ISSUE cycles without busReady before an access is abandoned.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: the read data returned on a timed-out access.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 cpuReq  input  1  processor requests a data access this cycle (level).
REQ-006 cpuAddr  input  32  access address.
REQ-007 cpuWData  input  32  write data.
REQ-008 cpuWE  input  1  1 = write, 0 = read.
REQ-009 cpuRData  output  32  read data returned to the processor.
REQ-010 cpuStall  output  1  processor holds its pc and flags while high.
REQ-011 busValid  output  1  request toward external memory.
REQ-012 busReady  input  1  memory accepts the request / data valid.
REQ-013 busAddr, busWData  output  32 each  latched request address and write data.
REQ-014 busWE  output  1  latched write enable.
REQ-015 busRData  input  32  memory read data, valid when busValid&busReady.
REQ-016 timeoutErr  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, DONE.
REQ-018 SHALL hold a one-entry read buffer consisting of bufValid, bufAddr[31:0] and bufData[31:0].
REQ-019 SHALL define hit = cpuReq & ~cpuWE & bufValid & (cpuAddr==bufAddr), evaluated in IDLE only.
REQ-020 In IDLE with a hit: cpuStall=0; cpuRData=bufData in the same cycle; state stays IDLE; no bus activity.
REQ-021 In IDLE with cpuReq=1 and no hit: cpuStall=1 combinationally in that cycle; at the edge, latch cpuAddr/cpuWData/cpuWE into busAddr/busWData/busWE, clear the timeout counter, and go to ISSUE.
REQ-022 In IDLE with cpuReq=0: cpuStall=0; state unchanged.
REQ-023 In ISSUE: busValid=1 and cpuStall=1; busAddr/busWData/busWE SHALL stay stable until the handshake completes.
REQ-024 On busValid&busReady in ISSUE: capture busRData on reads; go to DONE next cycle.
REQ-025 Read completion SHALL load the buffer: bufAddr=busAddr, bufData=busRData, bufValid=1.
REQ-026 Write completion with busAddr==bufAddr SHALL update bufData=busWData (write-through); a write to any other address leaves the buffer unchanged.
REQ-027 The timeout counter SHALL be 8 bits, increment on every ISSUE cycle without busReady, and saturate (no wrap).
REQ-028 When the counter equals TIMEOUT with busReady=0: drop busValid; set timeoutErr=1; set the captured data to ERR_DATA; clear bufValid; go to DONE.
REQ-029 busReady arriving in the same cycle as the counter reaching TIMEOUT SHALL count as success, not timeout.
REQ-030 In DONE: cpuStall=0 and busValid=0; cpuRData=captured data (reads) or 0 (writes); cpuReq is ignored; next state is always IDLE.
  - Rationale: the processor's request is still present during DONE and must not be reissued.
REQ-031 Latency: a miss read or a write SHALL stall for 1 + (cycles in ISSUE) cycles; a hit SHALL have zero stall.
REQ-032 cpuRData SHALL be 0 in all states/cycles not listed above.
REQ-033 timeoutErr SHALL clear only on reset.

Reset
REQ-034 While reset=0 at posedge clk: state=IDLE; bufValid=0; bufAddr=0; bufData=0; counter=0; timeoutErr=0; bus latches=0.
REQ-035 While reset is low: busValid=0, cpuStall=0, cpuRData=0.
REQ-036 Reset asserted mid-ISSUE SHALL abandon the access with no buffer update and no timeoutErr.

Verification
REQ-037 Read miss: cpuReq=1, cpuWE=0, cpuAddr=0x10; busReady high on the 3rd ISSUE cycle with busRData=0xCAFE0001 -> cpuStall high for 4 cycles; DONE cpuRData=0xCAFE0001; bufAddr=0x10.
REQ-038 Read hit: repeat the read of 0x10 -> cpuStall=0 and cpuRData=0xCAFE0001 in the same cycle; busValid never rises.
REQ-039 Write-through: write 0x12345678 to 0x10 with busReady=1 immediately, then read 0x10 -> hit returning 0x12345678 with no bus access.
REQ-040 Timeout: busReady held 0 -> busValid drops after 255 ISSUE cycles; DONE cpuRData=0xDEADBEEF; timeoutErr=1 until reset; the next read of the same address misses.
REQ-041 Boundary: busReady=1 exactly on the 255th ISSUE cycle -> success; timeoutErr stays 0.
REQ-042 Reset mid-ISSUE: reset=0 for 1 cycle during ISSUE -> next cycle IDLE, busValid=0, bufValid unchanged from 0, timeoutErr=0.
